// File: rtl/seven_seg_scan_counter.sv
// rtl/seven_seg_scan_counter.sv - multi-digit BCD up/down counter with multiplexed seven-segment scan
module seven_seg_scan_counter #(
    parameter int MS_LIMIT = 100000,
    parameter int DIGITS   = 4,
    parameter int TICK_MS  = 1000,
    parameter int SCAN_MS  = 1,
    parameter int BLANK_LZ = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  up_down,
    input  logic                  clear,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic                  tick
);

    localparam int MS_W   = (MS_LIMIT > 1) ? $clog2(MS_LIMIT) : 1;
    localparam int TICK_W = (TICK_MS  > 1) ? $clog2(TICK_MS)  : 1;
    localparam int SCAN_W = (SCAN_MS  > 1) ? $clog2(SCAN_MS)  : 1;
    localparam int IDX_W  = (DIGITS   > 1) ? $clog2(DIGITS)   : 1;

    logic [MS_W-1:0]     ms_cnt;
    logic [TICK_W-1:0]   tick_cnt;
    logic [SCAN_W-1:0]   scan_cnt;
    logic [IDX_W-1:0]    idx;
    logic                ms_pulse;
    logic                step;
    logic                scan_slot;
    logic [4*DIGITS-1:0] count_inc;
    logic [4*DIGITS-1:0] count_dec;
    logic                carry;
    logic                borrow;
    logic [3:0]          sel_digit;
    logic                sel_blank;
    logic                upper_zero;
    logic [7:0]          seg_next;

    function automatic logic [6:0] decode_digit(input logic [3:0] d);
        case (d)
            4'd0:    decode_digit = 7'h3F;
            4'd1:    decode_digit = 7'h06;
            4'd2:    decode_digit = 7'h5B;
            4'd3:    decode_digit = 7'h4F;
            4'd4:    decode_digit = 7'h66;
            4'd5:    decode_digit = 7'h6D;
            4'd6:    decode_digit = 7'h7D;
            4'd7:    decode_digit = 7'h07;
            4'd8:    decode_digit = 7'h7F;
            4'd9:    decode_digit = 7'h6F;
            default: decode_digit = 7'h00;
        endcase
    endfunction

    assign ms_pulse  = (ms_cnt == MS_W'(MS_LIMIT - 1));
    assign step      = ms_pulse && en && (tick_cnt == TICK_W'(TICK_MS - 1));
    assign scan_slot = ms_pulse && (scan_cnt == SCAN_W'(SCAN_MS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ms_cnt <= '0;
        end else if (ms_pulse) begin
            ms_cnt <= '0;
        end else begin
            ms_cnt <= ms_cnt + 1'b1;
        end
    end

    // Clear wins over a coincident step and restarts the full TICK_MS interval.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt  <= '0;
            count_bcd <= '0;
            tick      <= 1'b0;
        end else if (clear) begin
            tick_cnt  <= '0;
            count_bcd <= '0;
            tick      <= 1'b0;
        end else begin
            tick <= step;
            if (ms_pulse && en) begin
                if (step) begin
                    tick_cnt  <= '0;
                    count_bcd <= up_down ? count_inc : count_dec;
                end else begin
                    tick_cnt <= tick_cnt + 1'b1;
                end
            end
        end
    end

    // Ripple carry/borrow through the decades; an all-9s or all-0s count wraps naturally.
    always_comb begin
        count_inc = count_bcd;
        count_dec = count_bcd;
        carry     = 1'b1;
        borrow    = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (count_inc[4*i +: 4] >= 4'd9) begin
                    count_inc[4*i +: 4] = 4'd0;
                end else begin
                    count_inc[4*i +: 4] = count_inc[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
            if (borrow) begin
                if (count_dec[4*i +: 4] == 4'd0) begin
                    count_dec[4*i +: 4] = 4'd9;
                end else begin
                    count_dec[4*i +: 4] = count_dec[4*i +: 4] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
    end

    // Scanning from the top digit down lets upper_zero mean "this digit and all above are 0".
    always_comb begin
        sel_digit  = 4'd0;
        sel_blank  = 1'b0;
        upper_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero && (count_bcd[4*i +: 4] == 4'd0);
            if (idx == IDX_W'(i)) begin
                sel_digit = count_bcd[4*i +: 4];
                sel_blank = (BLANK_LZ != 0) && (i > 0) && upper_zero;
            end
        end
        seg_next = sel_blank ? 8'h00 : {1'b0, decode_digit(sel_digit)};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            idx      <= '0;
            an       <= '0;
            seg      <= '0;
        end else if (ms_pulse) begin
            if (scan_slot) begin
                scan_cnt <= '0;
                an       <= DIGITS'(1) << idx;
                seg      <= seg_next;
                idx      <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_counter.sv
// tb/tb_seven_seg_scan_counter.sv - scoreboard bench for seven_seg_scan_counter
`timescale 1ns/1ps
module tb_seven_seg_scan_counter;

    localparam int MS  = 4;
    localparam int TK  = 2;
    localparam int SC  = 1;
    localparam int ND  = 4;
    localparam int MOD = 10000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        up_down = 1'b1;
    logic        clear = 1'b0;
    logic [7:0]  seg, seg2;
    logic [3:0]  an, an2;
    logic [15:0] count_bcd, count_bcd2;
    logic        tick, tick2;

    int compared = 0;
    int mismatched = 0;

    seven_seg_scan_counter #(.MS_LIMIT(MS), .DIGITS(ND), .TICK_MS(TK), .SCAN_MS(SC), .BLANK_LZ(1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .up_down(up_down), .clear(clear),
        .seg(seg), .an(an), .count_bcd(count_bcd), .tick(tick)
    );

    seven_seg_scan_counter #(.MS_LIMIT(MS), .DIGITS(ND), .TICK_MS(TK), .SCAN_MS(SC), .BLANK_LZ(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .en(en), .up_down(up_down), .clear(clear),
        .seg(seg2), .an(an2), .count_bcd(count_bcd2), .tick(tick2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] an;
        logic [7:0] seg_b;
        logic [7:0] seg_nb;
    } scan_t;

    scan_t scan_q[$];
    int    tick_q[$];

    int    m_val = 0;
    int    m_edges = 0;
    int    m_tick_ms = 0;
    int    m_slots = 0;
    int    m_ms_in_slot = 0;
    int    m_old;
    int    m_idx;
    bit    m_ms;
    scan_t m_s;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] seg_of(input int d);
        case (d)
            0: seg_of = 8'h3F;  1: seg_of = 8'h06;  2: seg_of = 8'h5B;  3: seg_of = 8'h4F;
            4: seg_of = 8'h66;  5: seg_of = 8'h6D;  6: seg_of = 8'h7D;  7: seg_of = 8'h07;
            8: seg_of = 8'h7F;  9: seg_of = 8'h6F;  default: seg_of = 8'hFF;
        endcase
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < ND; i++) r[4*i +: 4] = 4'((v / (10 ** i)) % 10);
        return r;
    endfunction

    // Reference model: integer count modulo 10^ND, time measured in whole ms periods.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_val = 0; m_edges = 0; m_tick_ms = 0; m_slots = 0; m_ms_in_slot = 0;
                tick_q.delete();
                scan_q.delete();
            end else begin
                m_edges++;
                m_ms  = (m_edges % MS) == 0;
                m_old = m_val;
                if (m_ms) begin
                    m_ms_in_slot++;
                    if (m_ms_in_slot == SC) begin
                        m_ms_in_slot = 0;
                        m_idx    = m_slots % ND;
                        m_s.an     = 4'(1 << m_idx);
                        m_s.seg_nb = seg_of((m_old / (10 ** m_idx)) % 10);
                        m_s.seg_b  = (m_idx > 0 && (m_old / (10 ** m_idx)) == 0) ? 8'h00 : m_s.seg_nb;
                        scan_q.push_back(m_s);
                        m_slots++;
                    end
                end
                if (clear) begin
                    m_val = 0;
                    m_tick_ms = 0;
                end else if (m_ms && en) begin
                    m_tick_ms++;
                    if (m_tick_ms == TK) begin
                        m_tick_ms = 0;
                        m_val = up_down ? (m_val + 1) % MOD : (m_val + MOD - 1) % MOD;
                        tick_q.push_back(m_val);
                    end
                end
            end
        end
    end

    // Monitor: pops expected tick/scan events whenever the DUT presents them.
    logic [3:0] prev_an = 4'd0;
    int         exp_tick;
    scan_t      exp_scan;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_an = 4'd0;
            end else begin
                check("count_vs_model", count_bcd, to_bcd(m_val));
                check("count_nb_vs_model", count_bcd2, to_bcd(m_val));
                if (tick) begin
                    if (tick_q.size() == 0) begin
                        compared++; mismatched++;
                        $display("FAIL tick_unexpected: got tick=1 expected no step, count %0h", count_bcd);
                    end else begin
                        exp_tick = tick_q.pop_front();
                        check("tick_count", count_bcd, to_bcd(exp_tick));
                    end
                end else if (tick_q.size() != 0) begin
                    exp_tick = tick_q.pop_front();
                    compared++; mismatched++;
                    $display("FAIL tick_missing: got tick=0 expected tick with count %0h", to_bcd(exp_tick));
                end
                if (an != prev_an) begin
                    if (scan_q.size() == 0) begin
                        compared++; mismatched++;
                        $display("FAIL scan_unexpected: got an=%b expected no slot", an);
                    end else begin
                        exp_scan = scan_q.pop_front();
                        check("scan_an", an, exp_scan.an);
                        check("scan_an_nb", an2, exp_scan.an);
                        check("scan_seg_blank", seg, exp_scan.seg_b);
                        check("scan_seg_noblank", seg2, exp_scan.seg_nb);
                    end
                end else if (scan_q.size() != 0) begin
                    exp_scan = scan_q.pop_front();
                    compared++; mismatched++;
                    $display("FAIL scan_missing: got an=%b expected an=%b", an, exp_scan.an);
                end
                prev_an = an;
            end
        end
    end

    task automatic wait_tick(output int n);
        n = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (tick) begin
                n = k;
                break;
            end
        end
    endtask

    int n;
    int an_changes;
    int guard;
    logic [3:0] last_an;

    initial begin
        #2;
        check("reset_count", count_bcd, 16'h0000);
        check("reset_an", an, 4'h0);
        check("reset_seg", seg, 8'h00);
        check("reset_tick", tick, 1'b0);

        repeat (3) @(negedge clk);
        en = 1'b1; up_down = 1'b1; rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("an_before_first_slot", an, 4'h0);
        @(posedge clk);
        #1 check("an_first_slot", an, 4'b0001);
        wait_tick(n);
        check("first_tick_cycle", n + 4, 8);
        check("first_count", count_bcd, 16'h0001);
        wait_tick(n);
        check("second_tick_spacing", n, 8);
        check("second_count", count_bcd, 16'h0002);

        guard = 0;
        while (m_val != 100 && guard < 1200) begin
            @(negedge clk);
            guard++;
        end
        check("up_carry_0100", count_bcd, 16'h0100);

        @(negedge clk) clear = 1'b1;
        @(negedge clk) begin clear = 1'b0; up_down = 1'b0; end
        wait_tick(n);
        check("down_wrap_9999", count_bcd, 16'h9999);
        wait_tick(n);
        check("down_9998", count_bcd, 16'h9998);
        @(negedge clk) up_down = 1'b1;
        wait_tick(n);
        check("up_9999", count_bcd, 16'h9999);
        wait_tick(n);
        check("up_wrap_0000", count_bcd, 16'h0000);
        wait_tick(n);
        check("up_0001", count_bcd, 16'h0001);

        repeat (7) @(posedge clk);
        @(negedge clk) clear = 1'b1;
        @(posedge clk);
        #1;
        check("clear_on_step_tick", tick, 1'b0);
        check("clear_on_step_count", count_bcd, 16'h0000);
        @(negedge clk) clear = 1'b0;

        for (int k = 0; k < 7; k++) wait_tick(n);
        check("count_seven", count_bcd, 16'h0007);
        @(negedge clk) en = 1'b0;
        an_changes = 0;
        last_an = an;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (an != last_an) begin
                an_changes++;
                check("seven_seg_blank", seg, (an == 4'b0001) ? 8'h07 : 8'h00);
                check("seven_seg_noblank", seg2, (an == 4'b0001) ? 8'h07 : 8'h3F);
            end
            last_an = an;
        end
        check("frozen_count", count_bcd, 16'h0007);
        check("scan_while_frozen", an_changes, 10);

        repeat (2000) begin
            @(negedge clk);
            en      = ($urandom % 8) != 0;
            up_down = $urandom % 2;
            clear   = ($urandom % 64) == 0;
        end
        @(negedge clk) begin en = 1'b1; clear = 1'b0; up_down = 1'b1; end

        wait_tick(n);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_count", count_bcd, 16'h0000);
        check("midreset_an", an, 4'h0);
        check("midreset_seg", seg, 8'h00);
        check("midreset_tick", tick, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        wait_tick(n);
        check("tick_after_midreset", n, 8);
        check("count_after_midreset", count_bcd, 16'h0001);

        repeat (20) @(negedge clk);
        check("queues_drained", tick_q.size() + scan_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/seven_seg_scan_counter.md
SEVEN_SEG_SCAN_COUNTER -- requirements
Module: seven_seg_scan_counter

Interface
REQ-001 SHALL have parameter MS_LIMIT, default 100000: clk cycles per 1 ms time base (100 MHz clk).
REQ-002 SHALL have parameter DIGITS, default 4, range 1..8: number of BCD digits and display positions.
REQ-003 SHALL have parameter TICK_MS, default 1000: ms between count steps.
REQ-004 SHALL have parameter SCAN_MS, default 1: ms per digit refresh slot.
REQ-005 SHALL have parameter BLANK_LZ, default 1: 1 blanks leading zeros, 0 shows them.
REQ-006 SHALL have port clk, input, 1: single clock; all state SHALL be on its rising edge.
REQ-007 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-008 SHALL have port en, input, 1: 1 lets count steps occur; 0 freezes the count and the tick prescaler; the display scan continues.
REQ-009 SHALL have port up_down, input, 1: 1 counts up, 0 counts down; sampled on the step cycle.
REQ-010 SHALL have port clear, input, 1: synchronous count clear.
REQ-011 SHALL have port seg, output, 8: {dp,g,f,e,d,c,b,a}, active-high, registered.
REQ-012 SHALL have port an, output, DIGITS: one-hot active-high digit select, registered.
REQ-013 SHALL have port count_bcd, output, 4*DIGITS: digit i at bits [4i+3:4i], registered.
REQ-014 SHALL have port tick, output, 1: one-cycle pulse on each count step, registered.

Function
REQ-015 SHALL run the ms prescaler 0..MS_LIMIT-1, free-running; the cycle with value MS_LIMIT-1 SHALL form internal ms_pulse and SHALL wrap to 0.
REQ-016 SHALL advance the tick prescaler 0..TICK_MS-1 only on ms_pulse with en=1; ms_pulse at value TICK_MS-1 SHALL be a step: wrap to 0, update count_bcd, assert tick on the same edge.
REQ-017 Up step: digit 0 +1; a digit at 9 SHALL go to 0 and carry; all-9s SHALL wrap to all-0s.
REQ-018 Down step: digit 0 -1; a digit at 0 SHALL go to 9 and borrow; all-0s SHALL wrap to all-9s.
REQ-019 count_bcd digits SHALL never hold values 10..15.
REQ-020 clear=1 SHALL zero count_bcd and the tick prescaler on the next edge, SHALL override a coincident step, and SHALL suppress tick that cycle.
REQ-021 The scan SHALL run on every ms_pulse regardless of en. Each SCAN_MS ms_pulses SHALL be a scan slot: load an with one-hot of scan index idx, load seg with the decoded digit idx, then advance idx; DIGITS-1 SHALL wrap to 0.
REQ-022 seg SHALL use count_bcd as held before the edge; a step coinciding with a scan slot SHALL appear at the next slot.
REQ-023 Decode (hex, dp=0): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F.
REQ-024 With BLANK_LZ=1, digit i>0 SHALL show seg=00 when digits i..DIGITS-1 are all zero; an SHALL still assert. Digit 0 SHALL never be blanked.
REQ-025 Between scan slots an and seg SHALL hold; exactly one an bit SHALL be high after the first slot.

Reset
REQ-026 rst_n=0 SHALL asynchronously clear both prescalers, idx, count_bcd, seg, an and tick to 0.
REQ-027 Reset mid-count SHALL abort any pending step; after release, the first step SHALL come TICK_MS full ms periods later.
REQ-028 After release, an SHALL stay 0 until the first scan slot.

Verification (MS_LIMIT=4, TICK_MS=2, SCAN_MS=1, DIGITS=4, BLANK_LZ=1)
REQ-029 Release reset, en=1, up_down=1:
- tick on cycles 8, 16, 24, ...
- count_bcd = 0x0001, 0x0002, ... at those cycles.
REQ-030 Up wrap:
- preload to 0x0099 by steps; next step -> 0x0100.
- count 0x9999, next step -> 0x0000.
REQ-031 up_down=0 from 0x0000:
- one step -> 0x9999.
- next step -> 0x9998.
REQ-032 Count 0x0007, observe 4 scan slots:
- an = 0001/0010/0100/1000.
- seg = 07/00/00/00.
- with BLANK_LZ=0, seg = 07/3F/3F/3F.
REQ-033 Simultaneous events:
- clear coincident with a step -> count 0x0000, tick=0.
- en=0 for 40 cycles -> count frozen, an still rotating.
REQ-034 Mid-run rst_n pulse (1 cycle, off-edge) -> all outputs 0 immediately; next tick 8 cycles after release.
